// File: rtl/dly_prgrm_pkg.sv
// rtl/dly_prgrm_pkg.sv - shared constants, types and frame-bit helper for the delay programming controller
//
// Purpose: the frame layout and request type shared by the controller and its
//          arbiter.
// Contents: NUM_CH / CH_W / DLY_W field sizes, FRAME_LEN serial frame length,
//           RW_WRITE opcode bit, prg_state_e FSM encoding, prg_req_t request
//           record, frame_bit() mapping from bit index to serial data.
package dly_prgrm_pkg;

  localparam int   NUM_CH    = 4;
  localparam int   CH_W      = 2;
  localparam int   DLY_W     = 3;
  localparam int   FRAME_LEN = 6;
  localparam int   BIT_W     = 3;
  localparam logic RW_WRITE  = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } prg_state_e;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [DLY_W-1:0] dly;
  } prg_req_t;

  // Serial frame layout: opcode, ch lsb-first, dly lsb-first.
  function automatic logic frame_bit(input prg_req_t req, input logic [BIT_W-1:0] idx);
    logic b;
    b = RW_WRITE;
    case (idx)
      3'd1:    b = req.ch[0];
      3'd2:    b = req.ch[1];
      3'd3:    b = req.dly[0];
      3'd4:    b = req.dly[1];
      3'd5:    b = req.dly[2];
      default: b = RW_WRITE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dly_prgrm_rr_arb.sv
// rtl/dly_prgrm_rr_arb.sv - two-requester round-robin arbiter
//
// Purpose: picks one of two valid requesters; on a tie the pointer decides.
// Ports:
//   vld     in  2  request valid per requester
//   ptr     in  1  0 favours requester 0, 1 favours requester 1
//   gnt     out 2  one-hot grant, zero when nothing is valid
//   ptr_nxt out 1  pointer after this grant (favours the loser)
module dly_prgrm_rr_arb
  import dly_prgrm_pkg::*;
(
  input  logic [1:0] vld,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       ptr_nxt
);

  always_comb begin
    gnt     = vld;
    ptr_nxt = ptr;
    if (vld == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
    if (gnt[0]) begin
      ptr_nxt = 1'b1;
    end else if (gnt[1]) begin
      ptr_nxt = 1'b0;
    end
  end

endmodule

// File: rtl/dly_prgrm_ctrl.sv
// rtl/dly_prgrm_ctrl.sv - arbitrated serial programming controller for the four-channel delay datapath
//
// Purpose: accepts (channel, delay) writes from two requesters, serializes each
//          grant into a 6-bit prgrm_in/prgrm_go_ frame, keeps a shadow copy of
//          committed delays and latches datapath errors.
// Ports:
//   clk        in  1   system clock
//   rst        in  1   asynchronous active-high reset
//   req_vld    in  2   request valid per requester
//   req_rdy    out 2   grant/accept, one-hot or zero, only in IDLE
//   req_ch     in  4   channel per requester ([1:0] req0, [3:2] req1)
//   req_dly    in  6   delay per requester ([2:0] req0, [5:3] req1)
//   prgrm_in   out 1   serial programming data
//   prgrm_go_  out 1   active-low frame strobe
//   err_       in  1   active-low datapath error
//   err_clr    in  1   clears err_sticky (a simultaneous error wins)
//   busy       out 1   frame or inter-frame gap in progress
//   err_sticky out 1   latched error flag
//   shadow_dly out 12  last committed delay, channel N at [3N+2:3N]
module dly_prgrm_ctrl
  import dly_prgrm_pkg::*;
#(
  parameter int GAP_CYC = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_vld,
  output logic [1:0]              req_rdy,
  input  logic [2*CH_W-1:0]       req_ch,
  input  logic [2*DLY_W-1:0]      req_dly,
  output logic                    prgrm_in,
  output logic                    prgrm_go_,
  input  logic                    err_,
  input  logic                    err_clr,
  output logic                    busy,
  output logic                    err_sticky,
  output logic [NUM_CH*DLY_W-1:0] shadow_dly
);

  localparam int               GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_LEN - 1);

  prg_state_e       state, state_nxt;
  logic [BIT_W-1:0] bit_idx, bit_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  prg_req_t         frame, frame_nxt;
  logic             rr_ptr, ptr_nxt;
  logic             frame_err, frame_err_nxt;
  logic             in_nxt, go_nxt;
  logic             commit;
  logic [1:0]       arb_gnt;
  logic             arb_ptr_nxt;

  dly_prgrm_rr_arb u_arb (
    .vld     (req_vld),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .ptr_nxt (arb_ptr_nxt)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_idx   <= '0;
      gap_cnt   <= '0;
      frame     <= '0;
      rr_ptr    <= 1'b0;
      frame_err <= 1'b0;
      prgrm_in  <= 1'b0;
      prgrm_go_ <= 1'b1;
    end else begin
      state     <= state_nxt;
      bit_idx   <= bit_nxt;
      gap_cnt   <= gap_nxt;
      frame     <= frame_nxt;
      rr_ptr    <= ptr_nxt;
      frame_err <= frame_err_nxt;
      prgrm_in  <= in_nxt;
      prgrm_go_ <= go_nxt;
    end
  end

  // Next-state and next-output logic; prgrm_in/prgrm_go_ are registered one
  // cycle behind, so the grant cycle already computes bit 0 of the frame.
  always_comb begin
    state_nxt     = state;
    bit_nxt       = bit_idx;
    gap_nxt       = gap_cnt;
    frame_nxt     = frame;
    ptr_nxt       = rr_ptr;
    frame_err_nxt = frame_err;
    in_nxt        = 1'b0;
    go_nxt        = 1'b1;
    commit        = 1'b0;
    req_rdy       = 2'b00;
    case (state)
      IDLE: begin
        if (!rst && (arb_gnt != 2'b00)) begin
          req_rdy       = arb_gnt;
          ptr_nxt       = arb_ptr_nxt;
          frame_nxt.ch  = arb_gnt[1] ? req_ch[2*CH_W-1:CH_W]    : req_ch[CH_W-1:0];
          frame_nxt.dly = arb_gnt[1] ? req_dly[2*DLY_W-1:DLY_W] : req_dly[DLY_W-1:0];
          frame_err_nxt = 1'b0;
          bit_nxt       = '0;
          in_nxt        = RW_WRITE;
          go_nxt        = 1'b0;
          state_nxt     = SHIFT;
        end
      end
      SHIFT: begin
        // An error seen on the last bit still blocks this frame's commit.
        frame_err_nxt = frame_err | ~err_;
        if (bit_idx == BIT_LAST) begin
          commit    = ~(frame_err | ~err_);
          gap_nxt   = '0;
          state_nxt = GAP;
        end else begin
          bit_nxt = bit_idx + 1'b1;
          in_nxt  = frame_bit(frame, bit_idx + 1'b1);
          go_nxt  = 1'b0;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = IDLE;
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else begin
      err_sticky <= ~err_ | (err_sticky & ~err_clr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_dly <= '0;
    end else if (commit) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (frame.ch == CH_W'(i)) begin
          shadow_dly[i*DLY_W +: DLY_W] <= frame.dly;
        end
      end
    end
  end

endmodule

// File: tb/tb_dly_prgrm_ctrl.sv
// tb/tb_dly_prgrm_ctrl.sv - self-checking bench for dly_prgrm_ctrl
module tb_dly_prgrm_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_vld;
  logic [1:0]  req_rdy;
  logic [3:0]  req_ch;
  logic [5:0]  req_dly;
  logic        prgrm_in;
  logic        prgrm_go_;
  logic        err_;
  logic        err_clr;
  logic        busy;
  logic        err_sticky;
  logic [11:0] shadow_dly;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: per-channel delays, tie-break favourite, expected frames.
  logic [2:0] sh [4];
  logic       fav;
  logic [4:0] exp_q [$];

  dly_prgrm_ctrl #(.GAP_CYC(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_vld    (req_vld),
    .req_rdy    (req_rdy),
    .req_ch     (req_ch),
    .req_dly    (req_dly),
    .prgrm_in   (prgrm_in),
    .prgrm_go_  (prgrm_go_),
    .err_       (err_),
    .err_clr    (err_clr),
    .busy       (busy),
    .err_sticky (err_sticky),
    .shadow_dly (shadow_dly)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] pack_sh();
    logic [11:0] v;
    for (int i = 0; i < 4; i++) v[i*3 +: 3] = sh[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) sh[i] = 3'd0;
    fav = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Single-requester write; returns in the cycle carrying frame bit 0.
  task automatic send(input int p, input logic [1:0] ch, input logic [2:0] dly);
    int n;
    @(posedge clk); #1;
    if (p == 0) begin
      req_ch[1:0] = ch; req_dly[2:0] = dly;
    end else begin
      req_ch[3:2] = ch; req_dly[5:3] = dly;
    end
    req_vld[p] = 1'b1;
    n = 0;
    @(negedge clk);
    while (req_rdy === 2'b00 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("grant", 32'(req_rdy), 32'(2'b01 << p));
    exp_q.push_back({ch, dly});
    fav = (p == 0);
    @(posedge clk); #1;
    req_vld[p] = 1'b0;
  endtask

  // Protocol monitor and frame decoder.
  int         run = 0;
  logic [5:0] bits;
  logic [4:0] e;
  always @(negedge clk) begin
    if (rst) begin
      run = 0;
    end else begin
      if (req_rdy !== 2'b00) chk("rdy_while_busy", 32'(busy), 32'd0);
      if (prgrm_go_ === 1'b0) begin
        if (run == 0) chk("first_bit_write", 32'(prgrm_in), 32'd0);
        if (run < 6) bits[run] = prgrm_in;
        run++;
      end else if (run != 0) begin
        chk("go_low_len", 32'(run), 32'd6);
        if (run == 6) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("frame_data", 32'({bits[2:1], bits[5:3]}), 32'(e));
          end else begin
            chk("frame_unexpected", 32'd1, 32'd0);
          end
        end
        run = 0;
      end
    end
  end

  initial begin
    logic [1:0] rch, lch;
    logic [2:0] rdly;
    logic [5:0] fb;
    int         p, g, n, ep;
    int         gcyc [5];

    rst = 1'b1; err_ = 1'b1; err_clr = 1'b0;
    req_vld = 2'b00; req_ch = '0; req_dly = '0;
    model_reset();

    // Reset held with a pending request.
    rch = 2'($urandom_range(0, 3)); rdly = 3'($urandom_range(0, 7));
    req_ch[1:0] = rch; req_dly[2:0] = rdly; req_vld[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rdy", 32'(req_rdy), 32'd0);
    chk("rst_go", 32'(prgrm_go_), 32'd1);
    chk("rst_in", 32'(prgrm_in), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_sticky), 32'd0);
    chk("rst_shadow", 32'(shadow_dly), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_first_grant", 32'(req_rdy), 32'd1);
    exp_q.push_back({rch, rdly});
    fav = 1'b1;
    @(posedge clk); #1;
    req_vld[0] = 1'b0;
    wait_idle();
    sh[rch] = rdly;
    chk("rst_req_shadow", 32'(shadow_dly), 32'(pack_sh()));

    // Single write with bit-level timing.
    send(0, 2'd2, 3'd5);
    fb = {3'd5, 2'd2, 1'b0};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("single_go", 32'(prgrm_go_), 32'd0);
      chk("single_bit", 32'(prgrm_in), 32'(fb[k]));
    end
    @(negedge clk);
    chk("single_go_hi", 32'(prgrm_go_), 32'd1);
    chk("single_gap_busy", 32'(busy), 32'd1);
    sh[2] = 3'd5;
    chk("single_shadow", 32'(shadow_dly[8:6]), 32'd5);
    @(negedge clk);
    chk("single_busy_fall", 32'(busy), 32'd0);

    // Randomized writes, including delay extremes and a repeated channel.
    lch = 2'd0;
    for (int i = 0; i < 10; i++) begin
      p    = int'($urandom_range(0, 1));
      rch  = (i == 3) ? lch : 2'($urandom_range(0, 3));
      rdly = (i == 0) ? 3'd0 : (i == 1) ? 3'd7 : 3'($urandom_range(0, 7));
      lch  = rch;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(p, rch, rdly);
      wait_idle();
      sh[rch] = rdly;
      chk("rand_shadow", 32'(shadow_dly), 32'(pack_sh()));
    end

    // Arbitration with both requesters held valid, starting from reset.
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    req_ch = {2'd3, 2'd0}; req_dly = {3'd1, 3'd7}; req_vld = 2'b11;
    g = 0; n = 0;
    while (g < 5 && n < 200) begin
      @(negedge clk);
      n++;
      if (req_rdy !== 2'b00) begin
        ep = (req_vld == 2'b11) ? int'(fav) : (req_vld[1] ? 1 : 0);
        chk("arb_order", 32'(req_rdy), 32'(2'b01 << ep));
        exp_q.push_back(ep == 1 ? {2'd3, 3'd1} : {2'd0, 3'd7});
        sh[ep == 1 ? 3 : 0] = (ep == 1) ? 3'd1 : 3'd7;
        fav = (ep == 0);
        gcyc[g] = cyc;
        g++;
        if (g >= 4) begin
          @(posedge clk); #1;
          req_vld[ep] = 1'b0;
        end
      end
    end
    chk("arb_grants", 32'(g), 32'd5);
    for (int k = 1; k < g; k++) chk("arb_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'd8);
    wait_idle();
    chk("arb_shadow_model", 32'(shadow_dly), 32'(pack_sh()));
    chk("arb_shadow_const", 32'(shadow_dly), 32'b001_000_000_111);

    // Error latch: mid-frame error blocks the commit.
    send(0, 2'd1, 3'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    err_ = 1'b0;
    @(posedge clk); #1;
    err_ = 1'b1;
    @(negedge clk);
    chk("err_set", 32'(err_sticky), 32'd1);
    wait_idle();
    chk("err_shadow_kept", 32'(shadow_dly), 32'(pack_sh()));
    chk("err_still_set", 32'(err_sticky), 32'd1);
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    chk("err_clr", 32'(err_sticky), 32'd0);
    @(posedge clk); #1;
    err_ = 1'b0; err_clr = 1'b1;
    @(posedge clk); #1;
    err_ = 1'b1; err_clr = 1'b0;
    @(negedge clk);
    chk("err_set_wins", 32'(err_sticky), 32'd1);
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    send(1, 2'd1, 3'd3);
    wait_idle();
    sh[1] = 3'd3;
    chk("err_after_clr_commit", 32'(shadow_dly), 32'(pack_sh()));

    // Reset during bit 3 of a frame.
    send(0, 2'd1, 3'd6);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("midrst_go", 32'(prgrm_go_), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rdy", 32'(req_rdy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("midrst_shadow", 32'(shadow_dly[5:3]), 32'd0);
    chk("midrst_idle", 32'(busy), 32'd0);
    send(1, 2'd2, 3'd4);
    wait_idle();
    sh[2] = 3'd4;
    chk("midrst_after", 32'(shadow_dly), 32'(pack_sh()));
    chk("frames_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
